// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive controller: frame width, state encoding
// and the majority-vote helper used by the bit sampler.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line-side and counter-side signals of the UART receive controller.
// master: serial line and edge/bit counter side; slave: the receive FSM.
interface uart_rx_fsm_if
  import uart_rx_pkg::*;
;

  logic                 rx_in;
  logic [5:0]           prescale;
  logic                 par_en;
  logic                 par_typ;
  logic [3:0]           bit_cnt;
  logic [5:0]           edge_cnt;
  logic                 cnt_enable;
  logic [DATA_BITS-1:0] p_data;
  logic                 data_valid;
  logic                 par_err;
  logic                 stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ, bit_cnt, edge_cnt,
    input  cnt_enable, p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ, bit_cnt, edge_cnt,
    output cnt_enable, p_data, data_valid, par_err, stp_err
  );

endinterface

// File: rtl/uart_rx_fsm_data_sampling.sv
// Three-point mid-bit sampler; sampled_bit is the 2-of-3 vote and is valid
// from edge_cnt = prescale/2+2 until the end of the bit.
module data_sampling
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic [5:0] edge_cnt,
  input  logic       enable,
  output logic       sampled_bit
);

  logic [5:0] half;
  logic [2:0] smp;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      smp <= 3'b000;
    end else if (enable) begin
      if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
      if (edge_cnt == half)        smp[1] <= rx_in;
      if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
    end
  end

  assign sampled_bit = majority3(smp[0], smp[1], smp[2]);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller steering an external edge/bit counter.
// Parity state and par_err logic exist only when UART_RX_PARITY_EN is defined.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus
);

  rx_state_e            state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] p_data_q, p_data_nxt;
  logic                 dv_q, dv_nxt;
  logic                 done_q, done_nxt;
  logic                 stp_err_q, stp_err_nxt;
  logic                 par_err_q;
  logic                 cnt_en;
  logic                 bit_end;
  logic                 sampled_bit;
  logic                 data_bit_ok;
  logic [5:0]           last_edge;
  logic [2:0]           bit_idx;

`ifdef UART_RX_PARITY_EN
  logic par_err_nxt;
  logic par_en_q, par_en_nxt;
  logic par_typ_q, par_typ_nxt;
`else
  logic unused_par;
  assign par_err_q  = 1'b0;
  assign unused_par = bus.par_en ^ bus.par_typ;
`endif

  assign cnt_en      = (state != IDLE);
  assign last_edge   = bus.prescale - 6'd1;
  assign bit_end     = cnt_en && (bus.edge_cnt == last_edge);
  // Start bit is bit_cnt 0, so data bit n arrives with bit_cnt n+1.
  assign bit_idx     = 3'(bus.bit_cnt - 4'd1);
  assign data_bit_ok = (bus.bit_cnt != 4'd0) && (bus.bit_cnt <= 4'(DATA_BITS));

  data_sampling u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (bus.rx_in),
    .prescale    (bus.prescale),
    .edge_cnt    (bus.edge_cnt),
    .enable      (cnt_en),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shift     <= '0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      stp_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      p_data_q  <= p_data_nxt;
      dv_q      <= dv_nxt;
      done_q    <= done_nxt;
      stp_err_q <= stp_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_nxt;
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    p_data_nxt  = p_data_q;
    dv_nxt      = 1'b0;
    done_nxt    = 1'b0;
    stp_err_nxt = stp_err_q;
`ifdef UART_RX_PARITY_EN
    par_err_nxt = par_err_q;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
`endif

    // Delivery runs one clock after the stop bit, in parallel with a possible
    // back-to-back start, so it reads the flags before the start clears them.
    if (done_q && !par_err_q && !stp_err_q) begin
      p_data_nxt = shift;
      dv_nxt     = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!bus.rx_in) begin
          state_nxt   = START;
          stp_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_err_nxt = 1'b0;
          par_en_nxt  = bus.par_en;
          par_typ_nxt = bus.par_typ;
`endif
        end
      end
      START: begin
        if (bit_end) state_nxt = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (data_bit_ok) shift_nxt[bit_idx] = sampled_bit;
          // >= rather than == so a corrupted count still leaves DATA.
          if (bus.bit_cnt >= 4'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = par_en_q ? PARITY : STOP;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_err_nxt = sampled_bit ^ (^shift ^ par_typ_q);
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          stp_err_nxt = ~sampled_bit;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cnt_enable = cnt_en;
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: models the edge/bit counter, drives
// serial frames and scores delivered bytes against an expected-byte queue.
module tb_uart_rx_fsm;

  logic clk = 1'b0;
  logic rst;

  uart_rx_fsm_if bus ();

  uart_rx_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         vld_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_e;
  logic [7:0] last_good = 8'h00;
  logic       dv_prev = 1'b0;

  // Edge/bit counter: cleared while disabled, edge wraps at prescale-1.
  always_ff @(posedge clk) begin
    if (!bus.cnt_enable) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt  <= 4'd0;
    end else if (bus.edge_cnt == bus.prescale - 6'd1) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 6'd1;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      vld_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_valid p_data=%h required=no valid", bus.p_data);
      end else begin
        sb_e = exp_q.pop_front();
        if (bus.p_data !== sb_e) begin
          bad++;
          $display("FAIL sb_p_data got=%h required=%h", bus.p_data, sb_e);
        end
      end
      total++;
      if (dv_prev !== 1'b0) begin
        bad++;
        $display("FAIL valid_width data_valid high on consecutive clocks, prev=%b required=0", dv_prev);
      end
    end
    dv_prev = bus.data_valid;
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ps, input logic pen, input logic ptyp);
    bus.prescale = 6'(ps);
    bus.par_en   = pen;
    bus.par_typ  = ptyp;
  endtask

  task automatic drive_bit(input logic b, input int ps);
    bus.rx_in = b;
    repeat (ps) wait_clk();
  endtask

  task automatic send_tail(input logic [7:0] d, input int ps, input bit with_par,
                           input logic par_bit, input logic stop_bit);
    for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
    if (with_par) drive_bit(par_bit, ps);
    drive_bit(stop_bit, ps);
    bus.rx_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int ps, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0, ps);
    send_tail(d, ps, with_par, par_bit, stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rx_in = 1'b1;
    set_cfg(8, 1'b0, 1'b0);
    repeat (3) wait_clk();
    total++; if (bus.cnt_enable !== 1'b0) begin bad++; $display("FAIL rst_cnt_enable got=%b required=0", bus.cnt_enable); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid got=%b required=0", bus.data_valid); end
    total++; if (bus.p_data !== 8'h00) begin bad++; $display("FAIL rst_p_data got=%h required=00", bus.p_data); end
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL rst_par_err got=%b required=0", bus.par_err); end
    total++; if (bus.stp_err !== 1'b0) begin bad++; $display("FAIL rst_stp_err got=%b required=0", bus.stp_err); end
    rst = 1'b1;
    repeat (2) wait_clk();
  endtask

  task automatic test_no_parity();
    int v0;
    set_cfg(8, 1'b0, 1'b0);
    v0 = vld_seen;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL np_valid_count got=%0d required=%0d", vld_seen - v0, 1); end
    total++; if (bus.p_data !== 8'hA5) begin bad++; $display("FAIL np_p_data got=%h required=a5", bus.p_data); end
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL np_par_err got=%b required=0", bus.par_err); end
    total++; if (bus.stp_err !== 1'b0) begin bad++; $display("FAIL np_stp_err got=%b required=0", bus.stp_err); end
    last_good = 8'hA5;
  endtask

  task automatic test_parity();
    int v0;
`ifdef UART_RX_PARITY_EN
    set_cfg(16, 1'b1, 1'b0);
    v0 = vld_seen;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL par_good_count got=%0d required=%0d", vld_seen - v0, 1); end
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL par_good_err got=%b required=0", bus.par_err); end
    last_good = 8'h3C;
    v0 = vld_seen;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0) begin bad++; $display("FAIL par_bad_count got=%0d required=0", vld_seen - v0); end
    total++; if (bus.par_err !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b required=1", bus.par_err); end
    total++; if (bus.stp_err !== 1'b0) begin bad++; $display("FAIL par_bad_stp got=%b required=0", bus.stp_err); end
    total++; if (bus.p_data !== last_good) begin bad++; $display("FAIL par_bad_hold got=%h required=%h", bus.p_data, last_good); end
    set_cfg(16, 1'b1, 1'b1);
    v0 = vld_seen;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL par_odd_count got=%0d required=%0d", vld_seen - v0, 1); end
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL par_odd_err got=%b required=0", bus.par_err); end
`else
    // Parity disabled in the build: par_en is ignored and no parity bit is expected.
    set_cfg(16, 1'b1, 1'b0);
    v0 = vld_seen;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL nopar_count got=%0d required=%0d", vld_seen - v0, 1); end
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL nopar_par_err got=%b required=0", bus.par_err); end
    total++; if (bus.stp_err !== 1'b0) begin bad++; $display("FAIL nopar_stp_err got=%b required=0", bus.stp_err); end
`endif
    last_good = 8'h3C;
  endtask

  task automatic test_stop_error();
    int v0;
    set_cfg(8, 1'b0, 1'b0);
    v0 = vld_seen;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
    repeat (6) wait_clk();
    total++; if (bus.stp_err !== 1'b1) begin bad++; $display("FAIL stp_err_set got=%b required=1", bus.stp_err); end
    total++; if (vld_seen !== v0) begin bad++; $display("FAIL stp_no_valid got=%0d required=0", vld_seen - v0); end
    total++; if (bus.p_data !== last_good) begin bad++; $display("FAIL stp_hold got=%h required=%h", bus.p_data, last_good); end
    bus.rx_in = 1'b0;
    repeat (2) wait_clk();
    total++; if (bus.stp_err !== 1'b0) begin bad++; $display("FAIL stp_err_clear got=%b required=0", bus.stp_err); end
    repeat (6) wait_clk();
    exp_q.push_back(8'h55);
    send_tail(8'h55, 8, 1'b0, 1'b0, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL stp_next_count got=%0d required=%0d", vld_seen - v0, 1); end
    last_good = 8'h55;
  endtask

  task automatic test_glitch();
    int v0;
    set_cfg(8, 1'b0, 1'b0);
    v0 = vld_seen;
    bus.rx_in = 1'b0;
    repeat (2) wait_clk();
    bus.rx_in = 1'b1;
    repeat (6) wait_clk();
    total++; if (bus.cnt_enable !== 1'b1) begin bad++; $display("FAIL glitch_in_start got=%b required=1", bus.cnt_enable); end
    wait_clk();
    total++; if (bus.cnt_enable !== 1'b0) begin bad++; $display("FAIL glitch_back_idle got=%b required=0", bus.cnt_enable); end
    repeat (4) wait_clk();
    total++; if (bus.cnt_enable !== 1'b0) begin bad++; $display("FAIL glitch_stay_idle got=%b required=0", bus.cnt_enable); end
    total++; if (vld_seen !== v0) begin bad++; $display("FAIL glitch_no_valid got=%0d required=0", vld_seen - v0); end
    total++; if ({bus.par_err, bus.stp_err} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b required=00", {bus.par_err, bus.stp_err}); end
  endtask

  task automatic test_back_to_back();
    int v0;
    set_cfg(32, 1'b0, 1'b0);
    v0 = vld_seen;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    send_frame(8'h01, 32, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1);
    repeat (8) wait_clk();
    total++; if (vld_seen !== v0 + 2) begin bad++; $display("FAIL b2b_count got=%0d required=%0d", vld_seen - v0, 2); end
    total++; if (bus.p_data !== 8'hFF) begin bad++; $display("FAIL b2b_last got=%h required=ff", bus.p_data); end
    last_good = 8'hFF;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [7:0] d;
    d = 8'hC3;
    set_cfg(16, 1'b0, 1'b0);
    v0 = vld_seen;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
    bus.rx_in = d[4];
    repeat (8) wait_clk();
    rst = 1'b0;
    bus.rx_in = 1'b1;
    wait_clk();
    total++; if (bus.cnt_enable !== 1'b0) begin bad++; $display("FAIL mid_rst_cnt_enable got=%b required=0", bus.cnt_enable); end
    total++; if (bus.p_data !== 8'h00) begin bad++; $display("FAIL mid_rst_p_data got=%h required=00", bus.p_data); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b required=0", bus.data_valid); end
    total++; if ({bus.par_err, bus.stp_err} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags got=%b required=00", {bus.par_err, bus.stp_err}); end
    rst = 1'b1;
    repeat (4) wait_clk();
    total++; if (vld_seen !== v0) begin bad++; $display("FAIL mid_rst_no_valid got=%0d required=0", vld_seen - v0); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1);
    repeat (6) wait_clk();
    total++; if (vld_seen !== v0 + 1) begin bad++; $display("FAIL mid_rst_next_count got=%0d required=%0d", vld_seen - v0, 1); end
    total++; if (bus.p_data !== 8'h5A) begin bad++; $display("FAIL mid_rst_next_data got=%h required=5a", bus.p_data); end
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_in = 1'b1;
    set_cfg(8, 1'b0, 1'b0);
    test_reset();
    test_no_parity();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
